adder_issue_ctrl: RTL and testbench

//  Upstream issue stage for the registered adder (1-cycle latency, carry dropped).

---
 rtl/adder_pkg.sv | 31 +++
 rtl/adder_issue_ctrl_if.sv | 36 +++
 rtl/adder_issue_fifo.sv | 54 +++++
 rtl/adder_issue_ctrl.sv | 101 ++++++++++
 tb/tb_adder_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types for the adder issue stage: operand pairs, results, buffer depth.
// Carry tracking is present only when ADDER_ISSUE_OVF_EN is defined.
package adder_pkg;

    localparam int unsigned ADD_W     = 8;
    localparam int unsigned RES_DEPTH = 2;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
`ifdef ADDER_ISSUE_OVF_EN
        logic             ovf;
`endif
    } operand_pair_t;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
`ifdef ADDER_ISSUE_OVF_EN
        logic             ovf;
`endif
    } result_t;

    // A modular sum smaller than an operand means the add wrapped.
    function automatic logic carry_of(input logic [ADD_W-1:0] a,
                                      input logic [ADD_W-1:0] b);
        logic [ADD_W-1:0] s;
        s = a + b;
        return s < a;
    endfunction

endpackage

// File: rtl/adder_issue_ctrl_if.sv
// Producer, adder and consumer signals of the adder issue stage.
// out_ovf_o exists only when ADDER_ISSUE_OVF_EN is defined.
interface adder_issue_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_a_i;
    logic [WIDTH-1:0] in_b_i;
    logic [WIDTH-1:0] add_a_o;
    logic [WIDTH-1:0] add_b_o;
    logic [WIDTH-1:0] add_sum_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_sum_o;
`ifdef ADDER_ISSUE_OVF_EN
    logic             out_ovf_o;
`endif

    modport slave (
        input  in_valid_i, in_a_i, in_b_i, add_sum_i, out_ready_i,
`ifdef ADDER_ISSUE_OVF_EN
        output out_ovf_o,
`endif
        output in_ready_o, add_a_o, add_b_o, out_valid_o, out_sum_o
    );

    modport master (
        output in_valid_i, in_a_i, in_b_i, add_sum_i, out_ready_i,
`ifdef ADDER_ISSUE_OVF_EN
        input  out_ovf_o,
`endif
        input  in_ready_o, add_a_o, add_b_o, out_valid_o, out_sum_o
    );

endinterface

// File: rtl/adder_issue_fifo.sv
// Synchronous FIFO for the operand queue; ready is registered and is
// low during reset, so a push into a full queue is never accepted.
module adder_issue_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    output logic ready_o,
    input  logic pop_i,
    output T     data_o,
    output logic empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ready_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign ready_o = ready_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_o;
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != FULL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/adder_issue_ctrl.sv
// Issue stage for a 1-cycle registered adder with an in-order 2-entry result
// buffer. Define ADDER_ISSUE_OVF_EN to carry the add's carry-out to out_ovf_o.
module adder_issue_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_W,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_ni,
    adder_issue_ctrl_if.slave bus
);
    localparam int unsigned RW = $clog2(RES_DEPTH);

    operand_pair_t push_pair;
    operand_pair_t head;
    logic          fifo_empty;
    logic          issue;
    logic          pop;
    logic [2:0]    occ;

    result_t       res_q [RES_DEPTH];
    logic [RW-1:0] res_rd_q;
    logic [RW-1:0] res_wr_q;
    logic [1:0]    res_cnt_q;
    logic          inflight_q;
    result_t       cap;
`ifdef ADDER_ISSUE_OVF_EN
    logic          infl_ovf_q;
`endif

    always_comb begin
        push_pair     = '0;
        push_pair.a   = ADD_W'(bus.in_a_i);
        push_pair.b   = ADD_W'(bus.in_b_i);
`ifdef ADDER_ISSUE_OVF_EN
        push_pair.ovf = carry_of(push_pair.a, push_pair.b);
`endif
    end

    adder_issue_fifo #(
        .T     (operand_pair_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (bus.in_valid_i),
        .data_i  (push_pair),
        .ready_o (bus.in_ready_o),
        .pop_i   (issue),
        .data_o  (head),
        .empty_o (fifo_empty)
    );

    // Issue only if the result will have a slot when it comes back.
    assign pop   = (res_cnt_q != '0) && bus.out_ready_i;
    assign occ   = 3'(res_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue = !fifo_empty && (occ < 3'(RES_DEPTH));

    assign bus.add_a_o = issue ? WIDTH'(head.a) : '0;
    assign bus.add_b_o = issue ? WIDTH'(head.b) : '0;

    always_comb begin
        cap     = '0;
        cap.sum = ADD_W'(bus.add_sum_i);
`ifdef ADDER_ISSUE_OVF_EN
        cap.ovf = infl_ovf_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RES_DEPTH; i++) res_q[i] <= '0;
            res_rd_q   <= '0;
            res_wr_q   <= '0;
            res_cnt_q  <= '0;
            inflight_q <= 1'b0;
`ifdef ADDER_ISSUE_OVF_EN
            infl_ovf_q <= 1'b0;
`endif
        end else begin
            if (inflight_q) begin
                res_q[res_wr_q] <= cap;
                res_wr_q        <= res_wr_q + RW'(1);
            end
            if (pop) res_rd_q <= res_rd_q + RW'(1);
            res_cnt_q  <= res_cnt_q + 2'(inflight_q) - 2'(pop);
            inflight_q <= issue;
`ifdef ADDER_ISSUE_OVF_EN
            infl_ovf_q <= issue && head.ovf;
`endif
        end
    end

    assign bus.out_valid_o = (res_cnt_q != '0);
    assign bus.out_sum_o   = WIDTH'(res_q[res_rd_q].sum);
`ifdef ADDER_ISSUE_OVF_EN
    assign bus.out_ovf_o   = res_q[res_rd_q].ovf;
`endif

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Directed and randomised checks of adder_issue_ctrl with a registered
// adder model attached; prints one summary line at the end.
module tb_adder_issue_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    adder_issue_ctrl_if #(.WIDTH(8)) bus ();

    adder_issue_ctrl #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [7:0] add_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) add_q <= '0;
        else        add_q <= bus.add_a_o + bus.add_b_o;
    end
    assign bus.add_sum_i = add_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got[$];
    int         got_cyc[$];
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            got.push_back(bus.out_sum_o);
            got_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        output bit ok);
        ok = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_a_i     = a;
        bus.in_b_i     = b;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready_o) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic single(input vec_t v);
        bit ok;
        got.delete();
        bus.out_ready_i = 1'b1;
        push(v.a, v.b, ok);
        chk("single accept", 32'(ok), 1);
        chk("single valid E+1", 32'(bus.out_valid_o), 0);
        @(posedge clk); #1;
        chk("single valid E+2", 32'(bus.out_valid_o), 0);
        @(posedge clk); #1;
        chk("single valid E+3", 32'(bus.out_valid_o), 1);
        chk("single sum", 32'(bus.out_sum_o), 32'(v.sum));
`ifdef ADDER_ISSUE_OVF_EN
        chk("single ovf", 32'(bus.out_ovf_o), 32'(v.ovf));
`endif
        @(posedge clk); #1;
        chk("single drained", 32'(bus.out_valid_o), 0);
        chk("single count", got.size(), 1);
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 200 && got.size() < n; t++) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t       vecs[9];
    logic [7:0] expq[$];

    initial begin
        bit         ok;
        int         nrdy;
        int         bad;
        int         acc;
        int         ncyc;
        bit         took;
        logic [7:0] s;

        vecs[0] = '{8'd3,   8'd4,   8'd7,   1'b0};
        vecs[1] = '{8'd200, 8'd100, 8'd44,  1'b1};
        vecs[2] = '{8'd1,   8'd2,   8'd3,   1'b0};
        vecs[3] = '{8'd255, 8'd1,   8'd0,   1'b1};
        vecs[4] = '{8'd255, 8'd255, 8'd254, 1'b1};
        vecs[5] = '{8'd128, 8'd128, 8'd0,   1'b1};
        vecs[6] = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[7] = '{8'd17,  8'd25,  8'd42,  1'b0};
        vecs[8] = '{8'd127, 8'd128, 8'd255, 1'b0};

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_a_i      = '0;
        bus.in_b_i      = '0;
        bus.out_ready_i = 1'b1;

        #2;
        chk("reset in_ready", 32'(bus.in_ready_o), 0);
        chk("reset out_valid", 32'(bus.out_valid_o), 0);
        chk("reset out_sum", 32'(bus.out_sum_o), 0);
        chk("reset add_a", 32'(bus.add_a_o), 0);
`ifdef ADDER_ISSUE_OVF_EN
        chk("reset ovf", 32'(bus.out_ovf_o), 0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset in_ready", 32'(bus.in_ready_o), 1);

        for (int i = 0; i < 9; i++) single(vecs[i]);

        // back-to-back stream
        got.delete();
        got_cyc.delete();
        nrdy = 0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_a_i     = 8'(i);
            bus.in_b_i     = 8'(i);
            @(negedge clk);
            if (!bus.in_ready_o) nrdy++;
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        wait_got(16);
        chk("stream ready drops", nrdy, 0);
        chk("stream count", got.size(), 16);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 8'(2 * i)) bad++;
        chk("stream order", bad, 0);
        if (got_cyc.size() == 16)
            chk("stream rate", got_cyc[15] - got_cyc[0], 15);

        // backpressure fill then release
        got.delete();
        bus.out_ready_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            push(8'(10 * k), 8'(k), ok);
            chk("bp accept", 32'(ok), 1);
        end
        chk("bp ready after 6", 32'(bus.in_ready_o), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp ready held", 32'(bus.in_ready_o), 0);
        chk("bp valid", 32'(bus.out_valid_o), 1);
        chk("bp head", 32'(bus.out_sum_o), 11);
        chk("bp res count", 32'(dut.res_cnt_q), 2);
        chk("bp fifo count", 32'(dut.u_fifo.cnt_q), 4);
        chk("bp no issue", 32'(bus.add_a_o), 0);
        bus.out_ready_i = 1'b1;
        push(8'd70, 8'd7, ok);
        chk("bp accept 7", 32'(ok), 1);
        wait_got(7);
        chk("bp drain count", got.size(), 7);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 8'(11 * (i + 1))) bad++;
        chk("bp drain order", bad, 0);

        // random valid/ready
        got.delete();
        expq.delete();
        acc  = 0;
        ncyc = 0;
        while (acc < 1000 && ncyc < 20000) begin
            if (!bus.in_valid_i && $urandom_range(0, 99) < 70) begin
                bus.in_valid_i = 1'b1;
                bus.in_a_i     = 8'($urandom);
                bus.in_b_i     = 8'($urandom);
            end
            bus.out_ready_i = ($urandom_range(0, 99) < 60);
            @(negedge clk);
            took = bus.in_valid_i && bus.in_ready_o;
            if (took) begin
                s = bus.in_a_i + bus.in_b_i;
                expq.push_back(s);
                acc++;
            end
            @(posedge clk); #1;
            ncyc++;
            if (took) bus.in_valid_i = 1'b0;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int t = 0; t < 200 && got.size() < expq.size(); t++) begin
            @(posedge clk); #1;
        end
        repeat (5) begin @(posedge clk); #1; end
        chk("rand accepted", acc, 1000);
        chk("rand count", got.size(), expq.size());
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (got[i] !== expq[i]) bad++;
        chk("rand order", bad, 0);

        // reset with data in flight
        got.delete();
        bus.out_ready_i = 1'b0;
        push(8'd1, 8'd1, ok);
        push(8'd2, 8'd2, ok);
        push(8'd3, 8'd3, ok);
        bus.in_valid_i = 1'b1;
        bus.in_a_i     = 8'd9;
        bus.in_b_i     = 8'd9;
        @(posedge clk);
        #3 rst_n = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        chk("midrst in_ready", 32'(bus.in_ready_o), 0);
        chk("midrst out_valid", 32'(bus.out_valid_o), 0);
        chk("midrst out_sum", 32'(bus.out_sum_o), 0);
        chk("midrst add_a", 32'(bus.add_a_o), 0);
        chk("midrst add_b", 32'(bus.add_b_o), 0);
`ifdef ADDER_ISSUE_OVF_EN
        chk("midrst ovf", 32'(bus.out_ovf_o), 0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst ready after", 32'(bus.in_ready_o), 1);
        chk("midrst valid after", 32'(bus.out_valid_o), 0);
        bus.out_ready_i = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("midrst no stale", got.size(), 0);
        single('{8'd5, 8'd6, 8'd11, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
